// File: rtl/pin_settle.sv
// Bowling lane pin sensor front end: waits for the ball to clear, debounces the pin mask,
// and reports newly downed pins per roll. Optional strike fill pulse: PIN_SETTLE_STRIKE_FILL_EN.
module pin_settle #(
  parameter int unsigned SETTLE_CYCLES  = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       roll_start,
  input  logic       ball_done,
  input  logic [9:0] pins_down_raw,
  output logic       valid_out,
  output logic [9:0] pin_hit,
  output logic       chance,
  output logic       rack_reset,
  output logic       busy,
  output logic       roll_err
);

  typedef enum logic [2:0] {
    IDLE,
    ROLLING,
    SETTLING,
    REPORT,
    FILL,
    RACK
  } state_t;

  localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
  localparam logic [9:0]  ALL_PINS     = 10'h3FF;

  state_t      state;
  logic [19:0] timeout_cnt;
  logic [15:0] settle_cnt;
  logic [9:0]  sample;
  logic [9:0]  down_mask;

  // Result pulses and pin_hit are loaded on the edge entering the state that presents them,
  // so every output comes straight from a flop.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state       <= IDLE;
      timeout_cnt <= '0;
      settle_cnt  <= '0;
      sample      <= '0;
      down_mask   <= '0;
      valid_out   <= 1'b0;
      pin_hit     <= '0;
      chance      <= 1'b0;
      rack_reset  <= 1'b0;
      busy        <= 1'b0;
      roll_err    <= 1'b0;
    end else begin
      valid_out  <= 1'b0;
      pin_hit    <= '0;
      rack_reset <= 1'b0;

      if (roll_start && (state != IDLE)) begin
        roll_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (roll_start) begin
            state       <= ROLLING;
            timeout_cnt <= '0;
            busy        <= 1'b1;
          end
        end

        ROLLING: begin
          if (ball_done || (timeout_cnt == TIMEOUT_LAST)) begin
            state      <= SETTLING;
            settle_cnt <= '0;
            sample     <= pins_down_raw;
          end else begin
            timeout_cnt <= timeout_cnt + 20'd1;
          end
        end

        // Any change in the sensor word restarts the stability window.
        SETTLING: begin
          if (pins_down_raw != sample) begin
            sample     <= pins_down_raw;
            settle_cnt <= '0;
          end else if (settle_cnt == SETTLE_LAST) begin
            state     <= REPORT;
            valid_out <= 1'b1;
            pin_hit   <= sample & ~down_mask;
          end else begin
            settle_cnt <= settle_cnt + 16'd1;
          end
        end

        REPORT: begin
          down_mask <= down_mask | sample;
          if (chance) begin
            state      <= RACK;
            rack_reset <= 1'b1;
          end else if ((down_mask | sample) == ALL_PINS) begin
`ifdef PIN_SETTLE_STRIKE_FILL_EN
            state     <= FILL;
            valid_out <= 1'b1;
`else
            state      <= RACK;
            rack_reset <= 1'b1;
`endif
          end else begin
            chance <= 1'b1;
            state  <= IDLE;
            busy   <= 1'b0;
          end
        end

        FILL: begin
          state      <= RACK;
          rack_reset <= 1'b1;
        end

        RACK: begin
          down_mask <= '0;
          chance    <= 1'b0;
          state     <= IDLE;
          busy      <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
